// File: rtl/lsu_mem_port_if.sv
// Request, response and data-memory bus signals of the load/store memory port.
// The master modport is the environment (execute stage plus memory); slave is the port itself.
interface lsu_mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  inst_type;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        resp_valid;
  logic        resp_err;
  logic [1:0]  resp_err_code;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, inst_type, addr, store_data, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_err_code, load_data,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    input  req_valid, inst_type, addr, store_data, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_err_code, load_data,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store port: decodes inst_type, drives a word-addressed
// req/ack bus with byte enables and lane-steered store data, and extends load data.
module lsu_mem_port #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic           clk,
  input logic           rst,
  lsu_mem_port_if.slave io
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_reg;
  logic        req_ready_reg;
  logic        mem_req_reg;
  logic        mem_we_reg;
  logic [31:0] mem_addr_reg;
  logic [3:0]  mem_be_reg;
  logic [31:0] mem_wdata_reg;
  logic        resp_valid_reg;
  logic        resp_err_reg;
  logic [1:0]  resp_err_code_reg;
  logic [31:0] load_data_reg;
  logic [3:0]  inst_reg;
  logic [1:0]  addr_lo_reg;
  logic [15:0] cnt_reg;

  // Request decode
  logic        legal_next;
  logic        aligned_next;
  logic        size_b_next;
  logic        size_h_next;
  logic        store_next;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] load_ext_next;
  logic [31:0] rdata_shift;

  always_comb begin
    legal_next  = 1'b1;
    size_b_next = 1'b0;
    size_h_next = 1'b0;
    store_next  = 1'b0;
    case (io.inst_type)
      4'b1000, 4'b1011: size_b_next = 1'b1;
      4'b1001, 4'b1111: size_h_next = 1'b1;
      4'b1010:          ;
      4'b1100: begin size_b_next = 1'b1; store_next = 1'b1; end
      4'b1101: begin size_h_next = 1'b1; store_next = 1'b1; end
      4'b1110:          store_next = 1'b1;
      default:          legal_next = 1'b0;
    endcase

    if (size_b_next) begin
      aligned_next = 1'b1;
      be_next      = 4'b0001 << io.addr[1:0];
    end else if (size_h_next) begin
      aligned_next = ~io.addr[0];
      be_next      = 4'b0011 << io.addr[1:0];
    end else begin
      aligned_next = (io.addr[1:0] == 2'b00);
      be_next      = 4'b1111;
    end
  end

  // Each byte lane takes the low byte, the matching halfword byte, or its own byte
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_next[gi*8 +: 8] = size_b_next ? io.store_data[7:0] :
                                     size_h_next ? io.store_data[(gi%2)*8 +: 8] :
                                                   io.store_data[gi*8 +: 8];
    end
  endgenerate

  assign rdata_shift = io.mem_rdata >> {addr_lo_reg, 3'b000};

  always_comb begin
    case (inst_reg)
      4'b1000: load_ext_next = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      4'b1011: load_ext_next = {24'h0, rdata_shift[7:0]};
      4'b1001: load_ext_next = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      4'b1111: load_ext_next = {16'h0, rdata_shift[15:0]};
      4'b1010: load_ext_next = io.mem_rdata;
      default: load_ext_next = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      req_ready_reg     <= 1'b1;
      mem_req_reg       <= 1'b0;
      mem_we_reg        <= 1'b0;
      mem_addr_reg      <= 32'h0;
      mem_be_reg        <= 4'h0;
      mem_wdata_reg     <= 32'h0;
      resp_valid_reg    <= 1'b0;
      resp_err_reg      <= 1'b0;
      resp_err_code_reg <= 2'b00;
      load_data_reg     <= 32'h0;
      inst_reg          <= 4'h0;
      addr_lo_reg       <= 2'b00;
      cnt_reg           <= 16'h0;
    end else begin
      resp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (io.req_valid) begin
            inst_reg      <= io.inst_type;
            addr_lo_reg   <= io.addr[1:0];
            req_ready_reg <= 1'b0;
            load_data_reg <= 32'h0;
            if (!legal_next || !aligned_next) begin
              // Illegal code outranks misalignment
              state_reg         <= RESP;
              resp_valid_reg    <= 1'b1;
              resp_err_reg      <= 1'b1;
              resp_err_code_reg <= legal_next ? 2'b01 : 2'b10;
            end else begin
              state_reg     <= BUS;
              mem_req_reg   <= 1'b1;
              mem_we_reg    <= store_next;
              mem_addr_reg  <= {io.addr[31:2], 2'b00};
              mem_be_reg    <= be_next;
              mem_wdata_reg <= wdata_next;
              cnt_reg       <= 16'h0;
            end
          end
        end
        BUS: begin
          if (io.mem_ack) begin
            state_reg         <= RESP;
            mem_req_reg       <= 1'b0;
            resp_valid_reg    <= 1'b1;
            resp_err_reg      <= 1'b0;
            resp_err_code_reg <= 2'b00;
            load_data_reg     <= load_ext_next;
          end else if (cnt_reg == TO_LAST) begin
            state_reg         <= RESP;
            mem_req_reg       <= 1'b0;
            resp_valid_reg    <= 1'b1;
            resp_err_reg      <= 1'b1;
            resp_err_code_reg <= 2'b11;
            load_data_reg     <= 32'h0;
          end else begin
            cnt_reg <= cnt_reg + 16'h1;
          end
        end
        RESP: begin
          state_reg         <= IDLE;
          req_ready_reg     <= 1'b1;
          resp_err_reg      <= 1'b0;
          resp_err_code_reg <= 2'b00;
          load_data_reg     <= 32'h0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign io.req_ready     = req_ready_reg;
  assign io.mem_req       = mem_req_reg;
  assign io.mem_we        = mem_we_reg;
  assign io.mem_addr      = mem_addr_reg;
  assign io.mem_be        = mem_be_reg;
  assign io.mem_wdata     = mem_wdata_reg;
  assign io.resp_valid    = resp_valid_reg;
  assign io.resp_err      = resp_err_reg;
  assign io.resp_err_code = resp_err_code_reg;
  assign io.load_data     = load_data_reg;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: bus transactions, error codes, timeout and
// asynchronous reset abort, each scenario checked inline against hand-computed values.
module tb_lsu_mem_port;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  lsu_mem_port_if io ();

  lsu_mem_port #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1);
  end

  typedef struct packed {
    logic [3:0]  inst;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld;
    logic [3:0]  wait_n;
  } bus_vec_t;

  typedef struct packed {
    logic [3:0]  inst;
    logic [31:0] addr;
    logic [1:0]  code;
  } err_vec_t;

  task automatic drive_req(input logic [3:0] inst, input logic [31:0] a, input logic [31:0] d);
    io.req_valid  = 1'b1;
    io.inst_type  = inst;
    io.addr       = a;
    io.store_data = d;
    @(posedge clk); #1;
    io.req_valid  = 1'b0;
    io.inst_type  = 4'h0;
    io.addr       = 32'h0;
    io.store_data = 32'h0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (io.req_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", io.req_ready); else n_pass++;
    n_total++; if (io.mem_req !== 1'b0) $display("FAIL reset_mem_req got %b exp 0", io.mem_req); else n_pass++;
    n_total++; if (io.resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b exp 0", io.resp_valid); else n_pass++;
    n_total++; if (io.load_data !== 32'h0) $display("FAIL reset_load_data got %h exp 0", io.load_data); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_total++; if (io.req_ready !== 1'b1) $display("FAIL post_reset_ready got %b exp 1", io.req_ready); else n_pass++;
  endtask

  task automatic test_bus;
    bus_vec_t bv [9];
    logic [31:0] exp_addr;
    bv[0] = '{4'b1110, 32'h10000004, 32'hDEADBEEF, 32'h0,        1'b1, 4'b1111, 32'hDEADBEEF, 32'h0,        4'd0};
    bv[1] = '{4'b1000, 32'h10000003, 32'h0,        32'h80FF1234, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80, 4'd0};
    bv[2] = '{4'b1011, 32'h10000003, 32'h0,        32'h80FF1234, 1'b0, 4'b1000, 32'h0,        32'h00000080, 4'd1};
    bv[3] = '{4'b1001, 32'h10000002, 32'h0,        32'h80FF1234, 1'b0, 4'b1100, 32'h0,        32'hFFFF80FF, 4'd0};
    bv[4] = '{4'b1101, 32'h10000002, 32'h0000ABCD, 32'h0,        1'b1, 4'b1100, 32'hABCDABCD, 32'h0,        4'd2};
    bv[5] = '{4'b1111, 32'h10000006, 32'h0,        32'h92340000, 1'b0, 4'b1100, 32'h0,        32'h00009234, 4'd0};
    bv[6] = '{4'b1100, 32'h20000001, 32'h12345677, 32'h0,        1'b1, 4'b0010, 32'h77777777, 32'h0,        4'd0};
    bv[7] = '{4'b1010, 32'h20000008, 32'h0,        32'hCAFEF00D, 1'b0, 4'b1111, 32'h0,        32'hCAFEF00D, 4'd1};
    bv[8] = '{4'b1000, 32'h20000000, 32'h0,        32'h0000007F, 1'b0, 4'b0001, 32'h0,        32'h0000007F, 4'd0};
    for (int i = 0; i < 9; i++) begin
      exp_addr = bv[i].addr & 32'hFFFFFFFC;
      n_total++; if (io.req_ready !== 1'b1) $display("FAIL bus%0d_ready_before got %b exp 1", i, io.req_ready); else n_pass++;
      drive_req(bv[i].inst, bv[i].addr, bv[i].sdata);
      n_total++; if (io.mem_req !== 1'b1) $display("FAIL bus%0d_mem_req got %b exp 1", i, io.mem_req); else n_pass++;
      n_total++; if (io.req_ready !== 1'b0) $display("FAIL bus%0d_ready_busy got %b exp 0", i, io.req_ready); else n_pass++;
      n_total++; if (io.mem_we !== bv[i].we) $display("FAIL bus%0d_we got %b exp %b", i, io.mem_we, bv[i].we); else n_pass++;
      n_total++; if (io.mem_addr !== exp_addr) $display("FAIL bus%0d_addr got %h exp %h", i, io.mem_addr, exp_addr); else n_pass++;
      n_total++; if (io.mem_be !== bv[i].be) $display("FAIL bus%0d_be got %b exp %b", i, io.mem_be, bv[i].be); else n_pass++;
      if (bv[i].we) begin
        n_total++; if (io.mem_wdata !== bv[i].wdata) $display("FAIL bus%0d_wdata got %h exp %h", i, io.mem_wdata, bv[i].wdata); else n_pass++;
      end
      io.mem_rdata = 32'h5A5A5A5A;
      for (int w = 0; w < int'(bv[i].wait_n); w++) begin
        @(posedge clk); #1;
        n_total++; if (io.mem_req !== 1'b1 || io.resp_valid !== 1'b0)
          $display("FAIL bus%0d_wait%0d req/resp got %b%b exp 10", i, w, io.mem_req, io.resp_valid); else n_pass++;
      end
      io.mem_ack   = 1'b1;
      io.mem_rdata = bv[i].rdata;
      @(posedge clk); #1;
      io.mem_ack   = 1'b0;
      io.mem_rdata = 32'hA5A5A5A5;
      n_total++; if (io.resp_valid !== 1'b1) $display("FAIL bus%0d_resp_valid got %b exp 1", i, io.resp_valid); else n_pass++;
      n_total++; if (io.resp_err !== 1'b0 || io.resp_err_code !== 2'b00)
        $display("FAIL bus%0d_err got %b/%b exp 0/00", i, io.resp_err, io.resp_err_code); else n_pass++;
      n_total++; if (io.load_data !== bv[i].ld) $display("FAIL bus%0d_load_data got %h exp %h", i, io.load_data, bv[i].ld); else n_pass++;
      n_total++; if (io.mem_req !== 1'b0) $display("FAIL bus%0d_req_drop got %b exp 0", i, io.mem_req); else n_pass++;
      $display("txn bus%0d inst=%b addr=%h be=%b we=%b load_data=%h", i, bv[i].inst, bv[i].addr, io.mem_be, io.mem_we, io.load_data);
      @(posedge clk); #1;
      n_total++; if (io.resp_valid !== 1'b0 || io.req_ready !== 1'b1)
        $display("FAIL bus%0d_after valid/ready got %b%b exp 01", i, io.resp_valid, io.req_ready); else n_pass++;
    end
  endtask

  task automatic test_errors;
    err_vec_t ev [6];
    ev[0] = '{4'b1010, 32'h10000001, 2'b01};
    ev[1] = '{4'b1001, 32'h10000003, 2'b01};
    ev[2] = '{4'b1110, 32'h10000002, 2'b01};
    ev[3] = '{4'b0000, 32'h10000001, 2'b10};
    ev[4] = '{4'b0111, 32'h10000000, 2'b10};
    ev[5] = '{4'b0010, 32'h10000003, 2'b10};
    for (int i = 0; i < 6; i++) begin
      drive_req(ev[i].inst, ev[i].addr, 32'hFFFFFFFF);
      n_total++; if (io.resp_valid !== 1'b1) $display("FAIL err%0d_resp_valid got %b exp 1", i, io.resp_valid); else n_pass++;
      n_total++; if (io.resp_err !== 1'b1 || io.resp_err_code !== ev[i].code)
        $display("FAIL err%0d_code got %b/%b exp 1/%b", i, io.resp_err, io.resp_err_code, ev[i].code); else n_pass++;
      n_total++; if (io.mem_req !== 1'b0) $display("FAIL err%0d_mem_req got %b exp 0", i, io.mem_req); else n_pass++;
      n_total++; if (io.load_data !== 32'h0) $display("FAIL err%0d_load_data got %h exp 0", i, io.load_data); else n_pass++;
      $display("txn err%0d inst=%b addr=%h code=%b", i, ev[i].inst, ev[i].addr, io.resp_err_code);
      @(posedge clk); #1;
      n_total++; if (io.resp_valid !== 1'b0 || io.req_ready !== 1'b1 || io.mem_req !== 1'b0)
        $display("FAIL err%0d_after valid/ready/req got %b%b%b exp 010", i, io.resp_valid, io.req_ready, io.mem_req); else n_pass++;
    end
  endtask

  task automatic test_timeout;
    drive_req(4'b1010, 32'h30000000, 32'h0);
    for (int c = 0; c < 4; c++) begin
      n_total++; if (io.mem_req !== 1'b1 || io.resp_valid !== 1'b0)
        $display("FAIL to_cycle%0d req/resp got %b%b exp 10", c, io.mem_req, io.resp_valid); else n_pass++;
      @(posedge clk); #1;
    end
    n_total++; if (io.mem_req !== 1'b0) $display("FAIL to_req_drop got %b exp 0", io.mem_req); else n_pass++;
    n_total++; if (io.resp_valid !== 1'b1 || io.resp_err !== 1'b1 || io.resp_err_code !== 2'b11)
      $display("FAIL to_resp got %b%b/%b exp 11/11", io.resp_valid, io.resp_err, io.resp_err_code); else n_pass++;
    $display("txn timeout addr=30000000 code=%b", io.resp_err_code);
    @(posedge clk); #1;

    // Ack arriving on the last allowed cycle must beat the timeout
    drive_req(4'b1010, 32'h30000040, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (io.mem_req !== 1'b1) $display("FAIL to_ack_req4 got %b exp 1", io.mem_req); else n_pass++;
    io.mem_ack   = 1'b1;
    io.mem_rdata = 32'h13579BDF;
    @(posedge clk); #1;
    io.mem_ack   = 1'b0;
    n_total++; if (io.resp_valid !== 1'b1 || io.resp_err !== 1'b0 || io.resp_err_code !== 2'b00)
      $display("FAIL to_ack_resp got %b%b/%b exp 10/00", io.resp_valid, io.resp_err, io.resp_err_code); else n_pass++;
    n_total++; if (io.load_data !== 32'h13579BDF) $display("FAIL to_ack_data got %h exp 13579bdf", io.load_data); else n_pass++;
    $display("txn timeout_ack addr=30000040 err=%b load_data=%h", io.resp_err, io.load_data);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int budget;
    drive_req(4'b1010, 32'h40000020, 32'h0);
    n_total++; if (io.mem_req !== 1'b1) $display("FAIL rmid_req got %b exp 1", io.mem_req); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_total++; if (io.mem_req !== 1'b0) $display("FAIL rmid_async_drop got %b exp 0", io.mem_req); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_total++; if (io.resp_valid !== 1'b0 || io.req_ready !== 1'b1)
        $display("FAIL rmid_after%0d valid/ready got %b%b exp 01", c, io.resp_valid, io.req_ready); else n_pass++;
      @(posedge clk); #1;
    end
    budget = 0;
    while (io.req_ready !== 1'b1 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    n_total++; if (budget >= 20) $display("FAIL rmid_ready_wait got timeout exp ready"); else n_pass++;
    drive_req(4'b1010, 32'h40000024, 32'h0);
    io.mem_ack   = 1'b1;
    io.mem_rdata = 32'h01234567;
    @(posedge clk); #1;
    io.mem_ack   = 1'b0;
    n_total++; if (io.resp_valid !== 1'b1 || io.resp_err !== 1'b0 || io.load_data !== 32'h01234567)
      $display("FAIL rmid_next got %b%b/%h exp 10/01234567", io.resp_valid, io.resp_err, io.load_data); else n_pass++;
    $display("txn post_reset LW addr=40000024 load_data=%h", io.load_data);
    @(posedge clk); #1;
  endtask

  initial begin
    io.req_valid  = 1'b0;
    io.inst_type  = 4'h0;
    io.addr       = 32'h0;
    io.store_data = 32'h0;
    io.mem_ack    = 1'b0;
    io.mem_rdata  = 32'h0;
    test_reset;
    test_bus;
    test_errors;
    test_timeout;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Consumer side of the 4-bit `instType` memory-access code that the control decoder emits.
- Sits between the execute stage and the data-memory bus. Takes one load/store request at a time and drives a word-addressed bus with a req/ack handshake.
- Generates byte enables and store-lane steering; sign/zero-extends load data.
- Returns a single-cycle response with data or an error flag.

Parameters:
TIMEOUT_CYCLES, 255, max cycles to wait for mem_ack before aborting with error (1..65535)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present; sampled only when req_ready=1
req_ready  output  1  block idle and able to accept a request
inst_type  input  4  1000 LB, 1001 LH, 1010 LW, 1011 LBU, 1111 LHU, 1100 SB, 1101 SH, 1110 SW; all others illegal
addr  input  32  byte address (ALU result)
store_data  input  32  rs2 value, unshifted
resp_valid  output  1  one-cycle response strobe
resp_err  output  1  valid with resp_valid: misaligned, illegal code, or timeout
resp_err_code  output  2  00 none, 01 misaligned, 10 illegal inst_type, 11 timeout
load_data  output  32  extended load result; 0 for stores and errors
mem_req  output  1  bus request, held until mem_ack
mem_we  output  1  1 store, 0 load
mem_addr  output  32  {addr[31:2],2'b00}
mem_be  output  4  byte enables
mem_wdata  output  32  store data replicated to lanes
mem_ack  input  1  bus completion; ignored unless mem_req=1
mem_rdata  input  32  read word, valid with mem_ack on loads

Behaviour:
- Reset: all outputs 0 except req_ready=1; state IDLE; timeout counter 0. An async assert mid-transaction drops mem_req in the same cycle. No response is emitted for the aborted request.
- States: IDLE, BUS, RESP.
- IDLE: req_ready=1. On req_valid, latch inst_type, addr[1:0] and store data.
  - Legal and aligned -> BUS.
  - Otherwise -> RESP with the error code.
- Alignment rules:
  - Halfword (LH/LHU/SH) requires addr[0]=0.
  - Word (LW/SW) requires addr[1:0]=00.
  - Byte is always aligned.
  - If inst_type is illegal, code 10 takes priority over misalignment.
- BUS:
  - mem_req=1; mem_addr, mem_we, mem_be, mem_wdata stable and registered.
  - Counter increments each cycle without ack.
  - mem_ack -> RESP, with mem_rdata captured.
  - Counter reaching TIMEOUT_CYCLES without ack -> RESP with code 11; mem_req deasserts.
  - A mem_ack in the same cycle as the timeout wins (no error).
- mem_be:
  - Byte: 0001 << addr[1:0].
  - Half: 0011 << addr[1:0].
  - Word: 1111.
  - Loads drive the same be.
- mem_wdata:
  - SB: store_data[7:0] replicated ×4.
  - SH: store_data[15:0] replicated ×2.
  - SW: store_data.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0; next state IDLE.
  - load_data selects lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Latency:
  - Accepted in cycle N, mem_req in N+1.
  - Ack in cycle M -> resp_valid in M+1.
  - Zero-wait bus (ack in N+1): resp in N+2.
  - Error without bus access: resp_valid in N+1.
- One request in flight; req_valid while req_ready=0 is ignored (upstream holds).
- mem_req never asserted for error requests.

Test Plan:
- SW addr=0x1000_0004, data=0xDEADBEEF, ack one cycle after req -> mem_addr=0x10000004, be=1111, wdata=0xDEADBEEF, we=1; resp_valid two cycles after accept, err=0.
- LB addr=0x…03, mem_rdata=0x80FF_1234 -> be=1000, load_data=0xFFFFFF80. LBU same -> 0x00000080. LH addr=0x…02 -> be=1100, load_data=0xFFFF80FF.
- SH addr=0x…02, data=0x0000ABCD -> be=1100, wdata=0xABCDABCD. LW addr=0x…01 -> no mem_req, resp_err=1, code 01 one cycle after accept.
- inst_type=0000 with addr misaligned -> no bus access, code 10. inst_type=1111 LHU with addr=0x…06, rdata=0x9234_0000 -> load_data=0x00009234.
- TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles then drops; resp code 11. Rerun with ack on the 4th cycle -> err=0.
- rst pulsed while in BUS -> mem_req drops asynchronously, no resp_valid, req_ready=1 after release; the next request completes normally.
